processor_scheduler: RTL and testbench
======================================

Name: processor_scheduler

Overview:
- Initiator/consumer side of the window processor control and result interfaces.
- Scans a frame at one scale in raster order.
- Per window:
  - orders window-cache loads into the two double buffers;
  - sequences variance-threshold then cascade detection on the processor;
  - accepts the processor result;
  - republishes it with coordinates on a valid/taken output channel.
- Loads of the next window overlap detection of the current one.

Parameters:
- ROW_BITS, 10, width of x coordinate (integral row bits).
- COL_BITS, 10, width of y coordinate.
- SCALE_BITS, 5, width of scale index.
- STAGE_BITS, 5, width of numberOfStages (log2 supported cascade stages).
- FIXED_BITS, 32, width of fixed-point inv_window_area.

Ports:
- clk in 1: system clock.
- rst_n in 1: asynchronous active-low reset.
- frame_start in 1: one-cycle command, sampled only in IDLE.
- cfg_x_max in ROW_BITS: last window x; cfg_y_max in COL_BITS: last window y.
- cfg_step in 4: scan step, 0 treated as 1.
- cfg_scale in SCALE_BITS; cfg_stages in STAGE_BITS; cfg_inv_area in FIXED_BITS.
- frame_busy out 1: high from frame_start acceptance until last result taken.
- frame_done out 1: one-cycle pulse after last result taken.
- load_req out 1; load_x out ROW_BITS; load_y out COL_BITS; load_buf out 1: window-cache fill request, held until load_ack.
- load_ack in 1: fill complete.
- proc_startVar out 1; proc_readyVar in 1.
- proc_start out 1; proc_ready in 1.
- proc_done in 1.
- proc_valid in 1; proc_passfail in 1; proc_taken out 1.
- proc_dblBuf out 1; proc_numberOfStages out STAGE_BITS; proc_inv_window_area out FIXED_BITS.
- out_valid out 1; out_passfail out 1; out_x out ROW_BITS; out_y out COL_BITS; out_scale out SCALE_BITS.
- out_taken in 1: downstream accept.

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0;
  - FSM in IDLE;
  - counters 0;
  - result register empty.
- Config is latched at frame_start acceptance. frame_start while not IDLE is ignored.
- proc_numberOfStages, proc_inv_window_area and out_scale come from the latched values.
- Scan coordinates:
  - x advances by step; when x+step > x_max, x wraps to 0 and y += step.
  - The last window is the final (x,y) with y+step > y_max.
  - Arithmetic is one bit wider to prevent overflow wrap.
- Loader FSM L_IDLE/L_REQ:
  - issues load_req for the next coordinate into buffer !proc_dblBuf;
  - holds load_req/x/y/buf stable until load_ack;
  - marks that buffer full;
  - at most one outstanding load;
  - no load after the last coordinate has been issued.
- Main FSM:
  - IDLE: frame_start -> PRIME.
  - PRIME: wait for buffer 0 full -> VAR, with proc_dblBuf=0.
  - VAR: one-cycle proc_startVar, only in a cycle with proc_readyVar=1 -> WAITVAR.
  - WAITVAR: proc_readyVar=1 the cycle after the pulse or later -> START.
  - START: one-cycle proc_start, only when proc_ready=1 -> RUN.
  - RUN: wait proc_valid. On it, proc_taken pulses one cycle if the result register is empty or out_taken is high that cycle; otherwise stall.
    - Taking a result loads out_passfail/x/y and sets out_valid.
    - It also marks the current buffer empty.
    - If this window is the last -> DRAIN.
    - Else wait for the other buffer full, toggle proc_dblBuf -> VAR.
  - DRAIN: out_valid && out_taken -> IDLE, frame_done pulse.
- proc_done is monitored only for a protocol check: proc_done without a prior start flags an assertion. It has no functional effect.
- out_valid holds until out_taken; payload is stable while valid.
- out_taken and a new result in the same cycle: the register is overwritten, valid stays 1, no bubble.
- Single-window frame (x_max=y_max=0): exactly one load, one detection, one result.
- x_max < step: one column per row.
- rst_n low mid-frame: immediate return to IDLE; outstanding load_req dropped; the external load side is reset by the same rst_n.

Decomposition:
- Package pkg_processor_scheduler holds:
  - main and loader state enums;
  - a scan-coordinate struct {x,y};
  - the step-default constant.
- Widths derive from the existing global and integral-cache packages.
- Natural sub-module: window_scan_counter. It generates the raster (x,y) sequence with next/last outputs, and is instanced once for the loader.

Test Plan:
- x_max=4,y_max=2,step=2, immediate acks, out_taken tied 1 -> 6 results in order (0,0),(2,0),(4,0),(0,2),(2,2),(4,2); proc_dblBuf alternates 0,1,0,1,0,1; one frame_done.
- x_max=y_max=0 -> exactly one load_req (buf 0), one startVar, one start, one out_valid, frame_done.
- out_taken held 0 for 20 cycles after first result -> proc_taken withheld on the second proc_valid; no result lost; payload stable throughout.
- load_ack delayed 15 cycles per load -> processor not started on an unfilled buffer; load_req/x/y stable while waiting.
- rst_n asserted in RUN with load_req high -> all outputs 0 immediately. A new frame_start afterwards completes correctly from (0,0).
- frame_start pulsed while busy -> ignored; result count and latched scale unchanged.

Source files
------------

// File: rtl/pkg_processor_scheduler.sv
// Shared types and widths for the window processor scheduler.
//   - coordinate/scale/stage/fixed-point widths
//   - main and loader FSM state enums
//   - raster scan coordinate struct
//   - scan step used when the configured step is zero
package pkg_processor_scheduler;

    localparam int unsigned ROW_BITS   = 10;
    localparam int unsigned COL_BITS   = 10;
    localparam int unsigned SCALE_BITS = 5;
    localparam int unsigned STAGE_BITS = 5;
    localparam int unsigned FIXED_BITS = 32;

    localparam logic [3:0] STEP_DEFAULT = 4'd1;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StVar,
        StWaitVar,
        StStart,
        StRun,
        StDrain
    } main_state_e;

    typedef enum logic {
        LIdle,
        LReq
    } load_state_e;

    typedef struct packed {
        logic [ROW_BITS-1:0] x;
        logic [COL_BITS-1:0] y;
    } scan_coord_t;

    function automatic logic [3:0] eff_step(input logic [3:0] step);
        return (step == 4'd0) ? STEP_DEFAULT : step;
    endfunction

endpackage

// File: rtl/window_scan_counter.sv
// Raster-order window coordinate generator for one scale.
//   clk, rst_n          : clock, async active-low reset
//   clear_i             : restart the scan at (0,0)
//   advance_i           : step to the next raster coordinate
//   x_max_i, y_max_i    : last legal window x / y
//   step_i              : scan step (already non-zero)
//   coord_o             : current coordinate
//   last_o              : current coordinate is the final window of the frame
module window_scan_counter
    import pkg_processor_scheduler::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic [ROW_BITS-1:0] x_max_i,
    input  logic [COL_BITS-1:0] y_max_i,
    input  logic [3:0]          step_i,
    output scan_coord_t         coord_o,
    output logic                last_o
);

    scan_coord_t       coord_q, coord_d, coord_next;
    // One extra bit so x+step / y+step never wraps back below the limit.
    logic [ROW_BITS:0] x_sum;
    logic [COL_BITS:0] y_sum;
    logic              x_wrap, y_wrap;

    always_comb begin
        x_sum  = {1'b0, coord_q.x} + {{(ROW_BITS-3){1'b0}}, step_i};
        y_sum  = {1'b0, coord_q.y} + {{(COL_BITS-3){1'b0}}, step_i};
        x_wrap = x_sum > {1'b0, x_max_i};
        y_wrap = y_sum > {1'b0, y_max_i};

        coord_next = coord_q;
        if (!x_wrap) begin
            coord_next.x = x_sum[ROW_BITS-1:0];
        end else begin
            coord_next.x = '0;
            coord_next.y = y_sum[COL_BITS-1:0];
        end

        coord_d = coord_q;
        if (clear_i) begin
            coord_d = '0;
        end else if (advance_i) begin
            coord_d = coord_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coord_q <= '0;
        end else begin
            coord_q <= coord_d;
        end
    end

    assign coord_o = coord_q;
    assign last_o  = x_wrap && y_wrap;

endmodule

// File: rtl/processor_scheduler.sv
// Frame scheduler for the window processor: scans one scale in raster order, fills the two
// window-cache buffers ahead of detection, runs variance then cascade on each window and
// republishes each result with its coordinates.
//   frame_start_i / cfg_*_i       : frame command and configuration (latched at acceptance)
//   frame_busy_o / frame_done_o   : frame in progress / one-cycle completion pulse
//   load_*                        : window-cache fill request, held until load_ack_i
//   proc_*                        : window processor control and result handshake
//   out_*                         : result channel, valid held until out_taken_i
module processor_scheduler
    import pkg_processor_scheduler::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start_i,
    input  logic [ROW_BITS-1:0]   cfg_x_max_i,
    input  logic [COL_BITS-1:0]   cfg_y_max_i,
    input  logic [3:0]            cfg_step_i,
    input  logic [SCALE_BITS-1:0] cfg_scale_i,
    input  logic [STAGE_BITS-1:0] cfg_stages_i,
    input  logic [FIXED_BITS-1:0] cfg_inv_area_i,
    output logic                  frame_busy_o,
    output logic                  frame_done_o,
    output logic                  load_req_o,
    output logic [ROW_BITS-1:0]   load_x_o,
    output logic [COL_BITS-1:0]   load_y_o,
    output logic                  load_buf_o,
    input  logic                  load_ack_i,
    output logic                  proc_startVar_o,
    input  logic                  proc_readyVar_i,
    output logic                  proc_start_o,
    input  logic                  proc_ready_i,
    input  logic                  proc_done_i,
    input  logic                  proc_valid_i,
    input  logic                  proc_passfail_i,
    output logic                  proc_taken_o,
    output logic                  proc_dblBuf_o,
    output logic [STAGE_BITS-1:0] proc_numberOfStages_o,
    output logic [FIXED_BITS-1:0] proc_inv_window_area_o,
    output logic                  out_valid_o,
    output logic                  out_passfail_o,
    output logic [ROW_BITS-1:0]   out_x_o,
    output logic [COL_BITS-1:0]   out_y_o,
    output logic [SCALE_BITS-1:0] out_scale_o,
    input  logic                  out_taken_i
);

    main_state_e state_q, state_d;
    load_state_e lstate_q, lstate_d;

    logic [ROW_BITS-1:0]   x_max_q;
    logic [COL_BITS-1:0]   y_max_q;
    logic [3:0]            step_q;
    logic [SCALE_BITS-1:0] scale_q;
    logic [STAGE_BITS-1:0] stages_q;
    logic [FIXED_BITS-1:0] inv_area_q;

    logic        dbl_buf_q;
    logic        next_buf_q;
    logic        issued_all_q;
    logic [1:0]  buf_full_q, buf_full_d;
    logic [1:0]  buf_last_q;
    scan_coord_t buf_coord_q [2];

    logic        out_valid_q, out_passfail_q;
    scan_coord_t out_coord_q;
    logic        frame_done_q;
    logic        started_q;

    logic        accept, take, load_fire, cur_last;
    scan_coord_t scan_coord;
    logic        scan_last;

    assign accept    = (state_q == StIdle) && frame_start_i;
    assign load_fire = (lstate_q == LReq) && load_ack_i;
    assign cur_last  = buf_last_q[dbl_buf_q];
    // A result is taken only if the output register is free or being drained this cycle.
    assign take      = (state_q == StRun) && proc_valid_i && (!out_valid_q || out_taken_i);

    window_scan_counter u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (accept),
        .advance_i (load_fire),
        .x_max_i   (x_max_q),
        .y_max_i   (y_max_q),
        .step_i    (step_q),
        .coord_o   (scan_coord),
        .last_o    (scan_last)
    );

    // Main FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Main FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (frame_start_i) state_d = StPrime;
            StPrime:   if (buf_full_q[dbl_buf_q]) state_d = StVar;
            StVar:     if (proc_readyVar_i) state_d = StWaitVar;
            StWaitVar: if (proc_readyVar_i) state_d = StStart;
            StStart:   if (proc_ready_i) state_d = StRun;
            StRun:     if (take) state_d = cur_last ? StDrain : StPrime;
            StDrain:   if (out_valid_q && out_taken_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Main FSM: outputs.
    always_comb begin
        frame_busy_o    = (state_q != StIdle);
        proc_startVar_o = (state_q == StVar) && proc_readyVar_i;
        proc_start_o    = (state_q == StStart) && proc_ready_i;
        proc_taken_o    = take;
    end

    // Loader FSM: one outstanding fill, always into the buffer after the last one filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate_q <= LIdle;
        end else begin
            lstate_q <= lstate_d;
        end
    end

    always_comb begin
        lstate_d = lstate_q;
        unique case (lstate_q)
            LIdle: if ((state_q != StIdle) && !issued_all_q && !buf_full_q[next_buf_q]) begin
                lstate_d = LReq;
            end
            LReq:  if (load_ack_i) lstate_d = LIdle;
            default: lstate_d = LIdle;
        endcase
    end

    always_comb begin
        buf_full_d = buf_full_q;
        if (accept) begin
            buf_full_d = '0;
        end else begin
            if (load_fire) buf_full_d[next_buf_q] = 1'b1;
            if (take)      buf_full_d[dbl_buf_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_buf_q     <= 1'b0;
            issued_all_q   <= 1'b0;
            buf_full_q     <= '0;
            buf_last_q     <= '0;
            buf_coord_q[0] <= '0;
            buf_coord_q[1] <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            if (accept) begin
                next_buf_q   <= 1'b0;
                issued_all_q <= 1'b0;
            end else if (load_fire) begin
                next_buf_q              <= ~next_buf_q;
                issued_all_q            <= scan_last;
                buf_coord_q[next_buf_q] <= scan_coord;
                buf_last_q[next_buf_q]  <= scan_last;
            end
        end
    end

    // Configuration, buffer selection and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_max_q        <= '0;
            y_max_q        <= '0;
            step_q         <= '0;
            scale_q        <= '0;
            stages_q       <= '0;
            inv_area_q     <= '0;
            dbl_buf_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_passfail_q <= 1'b0;
            out_coord_q    <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            frame_done_q <= (state_q == StDrain) && out_valid_q && out_taken_i;
            if (accept) begin
                x_max_q    <= cfg_x_max_i;
                y_max_q    <= cfg_y_max_i;
                step_q     <= eff_step(cfg_step_i);
                scale_q    <= cfg_scale_i;
                stages_q   <= cfg_stages_i;
                inv_area_q <= cfg_inv_area_i;
                dbl_buf_q  <= 1'b0;
            end
            if (take) begin
                out_valid_q    <= 1'b1;
                out_passfail_q <= proc_passfail_i;
                out_coord_q    <= buf_coord_q[dbl_buf_q];
                if (!cur_last) dbl_buf_q <= ~dbl_buf_q;
            end else if (out_taken_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Tracks an in-flight detection so a stray proc_done can be flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
        end else if (proc_start_o) begin
            started_q <= 1'b1;
        end else if (proc_done_i) begin
            started_q <= 1'b0;
        end
    end

    done_after_start: assert property (@(posedge clk) disable iff (!rst_n)
        proc_done_i |-> started_q);

    assign frame_done_o           = frame_done_q;
    assign load_req_o             = (lstate_q == LReq);
    assign load_x_o               = scan_coord.x;
    assign load_y_o               = scan_coord.y;
    assign load_buf_o             = next_buf_q;
    assign proc_dblBuf_o          = dbl_buf_q;
    assign proc_numberOfStages_o  = stages_q;
    assign proc_inv_window_area_o = inv_area_q;
    assign out_valid_o            = out_valid_q;
    assign out_passfail_o         = out_passfail_q;
    assign out_x_o                = out_coord_q.x;
    assign out_y_o                = out_coord_q.y;
    assign out_scale_o            = scale_q;

endmodule

// File: tb/tb_processor_scheduler.sv
module tb_processor_scheduler;
    import pkg_processor_scheduler::*;

    logic clk, rst_n;
    logic frame_start_i;
    logic [ROW_BITS-1:0] cfg_x_max_i;
    logic [COL_BITS-1:0] cfg_y_max_i;
    logic [3:0] cfg_step_i;
    logic [SCALE_BITS-1:0] cfg_scale_i;
    logic [STAGE_BITS-1:0] cfg_stages_i;
    logic [FIXED_BITS-1:0] cfg_inv_area_i;
    logic frame_busy_o, frame_done_o, load_req_o, load_buf_o, load_ack_i;
    logic [ROW_BITS-1:0] load_x_o, out_x_o;
    logic [COL_BITS-1:0] load_y_o, out_y_o;
    logic proc_startVar_o, proc_readyVar_i, proc_start_o, proc_ready_i, proc_done_i;
    logic proc_valid_i, proc_passfail_i, proc_taken_o, proc_dblBuf_o;
    logic [STAGE_BITS-1:0] proc_numberOfStages_o;
    logic [FIXED_BITS-1:0] proc_inv_window_area_o;
    logic out_valid_o, out_passfail_o, out_taken_i;
    logic [SCALE_BITS-1:0] out_scale_o;

    processor_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start_i),
        .cfg_x_max_i(cfg_x_max_i), .cfg_y_max_i(cfg_y_max_i), .cfg_step_i(cfg_step_i),
        .cfg_scale_i(cfg_scale_i), .cfg_stages_i(cfg_stages_i), .cfg_inv_area_i(cfg_inv_area_i),
        .frame_busy_o(frame_busy_o), .frame_done_o(frame_done_o),
        .load_req_o(load_req_o), .load_x_o(load_x_o), .load_y_o(load_y_o),
        .load_buf_o(load_buf_o), .load_ack_i(load_ack_i),
        .proc_startVar_o(proc_startVar_o), .proc_readyVar_i(proc_readyVar_i),
        .proc_start_o(proc_start_o), .proc_ready_i(proc_ready_i), .proc_done_i(proc_done_i),
        .proc_valid_i(proc_valid_i), .proc_passfail_i(proc_passfail_i),
        .proc_taken_o(proc_taken_o), .proc_dblBuf_o(proc_dblBuf_o),
        .proc_numberOfStages_o(proc_numberOfStages_o),
        .proc_inv_window_area_o(proc_inv_window_area_o),
        .out_valid_o(out_valid_o), .out_passfail_o(out_passfail_o), .out_x_o(out_x_o),
        .out_y_o(out_y_o), .out_scale_o(out_scale_o), .out_taken_i(out_taken_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int xm; int ym; int st; int sc; int stg; int ack; int tmode;
        int lmin; int lmax; int poke; int exp_n;
    } vec_t;

    typedef struct { int x; int y; int pf; } res_t;

    int total = 0;
    int bad = 0;

    // Reference model state.
    int ex[$];
    int ey[$];
    int n_exp, exp_scale, exp_stages, exp_inv;
    int ld_k, win_k, var_cnt, start_cnt, res_cnt, fd_cnt, withheld;
    int filled [2];
    int bx [2];
    int by [2];
    res_t outq[$];
    int ack_delay, ack_wait, taken_mode, hold_cnt, lat_min, lat_max, run_cnt;
    bit hold_started, req_seen, running, pv, ppf;
    int req_x, req_y, req_b;

    task automatic check_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        ld_k = 0; win_k = 0; var_cnt = 0; start_cnt = 0; res_cnt = 0; fd_cnt = 0;
        withheld = 0; filled[0] = 0; filled[1] = 0; outq.delete();
        req_seen = 0; running = 0; pv = 0; ppf = 0; hold_started = 0; hold_cnt = 0;
    endtask

    // Environment: cache loader, window processor and downstream consumer, plus checks.
    initial begin
        load_ack_i = 0; proc_readyVar_i = 0; proc_ready_i = 0; proc_done_i = 0;
        proc_valid_i = 0; proc_passfail_i = 0; out_taken_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                load_ack_i = 0; proc_valid_i = 0; proc_done_i = 0; out_taken_i = 0;
                continue;
            end
            load_ack_i = 0;
            if (load_req_o) begin
                if (!req_seen) begin
                    req_seen = 1; ack_wait = 0;
                    req_x = int'(load_x_o); req_y = int'(load_y_o); req_b = int'(load_buf_o);
                end else begin
                    check_eq("load_hold_x", int'(load_x_o), req_x);
                    check_eq("load_hold_y", int'(load_y_o), req_y);
                    check_eq("load_hold_buf", int'(load_buf_o), req_b);
                end
                if (ack_wait >= ack_delay) begin
                    load_ack_i = 1; req_seen = 0;
                    if (ld_k < n_exp) begin
                        check_eq("load_x", int'(load_x_o), ex[ld_k]);
                        check_eq("load_y", int'(load_y_o), ey[ld_k]);
                        check_eq("load_buf", int'(load_buf_o), ld_k % 2);
                    end else begin
                        check_eq("load_count", ld_k + 1, n_exp);
                    end
                    filled[load_buf_o] = 1;
                    bx[load_buf_o] = int'(load_x_o);
                    by[load_buf_o] = int'(load_y_o);
                    ld_k++;
                end else begin
                    ack_wait++;
                end
            end
            proc_done_i = 0;
            proc_readyVar_i = ($urandom_range(0, 3) != 0);
            proc_ready_i = ($urandom_range(0, 3) != 0);
            if (running) begin
                if (run_cnt == 0) begin
                    pv = 1; ppf = 1'($urandom); proc_done_i = 1; running = 0;
                end else begin
                    run_cnt--;
                end
            end
            proc_valid_i = pv;
            proc_passfail_i = ppf;
            if (taken_mode == 0) begin
                out_taken_i = 1;
            end else if (taken_mode == 1) begin
                out_taken_i = 1'($urandom);
            end else begin
                if (out_valid_o && !hold_started) begin
                    hold_started = 1; hold_cnt = 20;
                end
                out_taken_i = (hold_cnt == 0);
                if (hold_cnt > 0) hold_cnt--;
            end
            #1;
            if (frame_done_o) fd_cnt++;
            if (proc_startVar_o) begin
                check_eq("startvar_ready", int'(proc_readyVar_i), 1);
                check_eq("startvar_seq", var_cnt, win_k);
                check_eq("dblbuf", int'(proc_dblBuf_o), var_cnt % 2);
                check_eq("buf_filled", filled[proc_dblBuf_o], 1);
                if (win_k < n_exp) begin
                    check_eq("buf_x", bx[proc_dblBuf_o], ex[win_k]);
                    check_eq("buf_y", by[proc_dblBuf_o], ey[win_k]);
                end
                var_cnt++;
            end
            if (proc_start_o) begin
                check_eq("start_ready", int'(proc_ready_i), 1);
                check_eq("start_after_var", start_cnt + 1, var_cnt);
                check_eq("stages", int'(proc_numberOfStages_o), exp_stages);
                check_eq("inv_area", int'(proc_inv_window_area_o), exp_inv);
                start_cnt++;
                running = 1;
                run_cnt = $urandom_range(lat_max, lat_min);
            end
            check_eq("proc_taken", int'(proc_taken_o),
                     int'(pv && (!out_valid_o || out_taken_i)));
            if (pv && out_valid_o && !out_taken_i) withheld++;
            check_eq("out_valid", int'(out_valid_o), int'(outq.size() != 0));
            if (out_valid_o && outq.size() != 0) begin
                check_eq("out_x", int'(out_x_o), outq[0].x);
                check_eq("out_y", int'(out_y_o), outq[0].y);
                check_eq("out_pf", int'(out_passfail_o), outq[0].pf);
                check_eq("out_scale", int'(out_scale_o), exp_scale);
                if (out_taken_i) begin
                    void'(outq.pop_front());
                    res_cnt++;
                end
            end
            if (proc_taken_o) begin
                if (win_k < n_exp) outq.push_back('{ex[win_k], ey[win_k], int'(ppf)});
                filled[proc_dblBuf_o] = 0;
                win_k++;
                pv = 0;
            end
        end
    end

    task automatic start_frame(input vec_t v);
        int s;
        clear_model();
        ack_delay = v.ack; taken_mode = v.tmode; lat_min = v.lmin; lat_max = v.lmax;
        s = (v.st == 0) ? 1 : v.st;
        ex.delete(); ey.delete();
        for (int y = 0; y <= v.ym; y += s) begin
            for (int x = 0; x <= v.xm; x += s) begin
                ex.push_back(x); ey.push_back(y);
            end
        end
        n_exp = ex.size();
        exp_scale = v.sc; exp_stages = v.stg; exp_inv = int'($urandom);
        @(negedge clk);
        cfg_x_max_i = ROW_BITS'(v.xm); cfg_y_max_i = COL_BITS'(v.ym);
        cfg_step_i = 4'(v.st); cfg_scale_i = SCALE_BITS'(v.sc);
        cfg_stages_i = STAGE_BITS'(v.stg); cfg_inv_area_i = exp_inv;
        frame_start_i = 1;
        @(negedge clk);
        frame_start_i = 0;
        #2;
        check_eq("busy_after_start", int'(frame_busy_o), 1);
    endtask

    task automatic wait_frame(input vec_t v);
        for (int c = 0; c < 5000 && fd_cnt == 0; c++) begin
            @(negedge clk);
            if (v.poke != 0 && c == 10 && frame_busy_o) begin
                frame_start_i = 1;
                cfg_scale_i = ~SCALE_BITS'(v.sc);
                cfg_x_max_i = '0;
            end else begin
                frame_start_i = 0;
            end
            #2;
        end
        frame_start_i = 0;
        if (fd_cnt == 0) begin
            check_eq("frame_timeout", 0, 1);
        end else begin
            repeat (3) @(negedge clk);
            #2;
            check_eq("frame_done_count", fd_cnt, 1);
            check_eq("result_count", res_cnt, v.exp_n);
            check_eq("load_total", ld_k, v.exp_n);
            check_eq("var_total", var_cnt, v.exp_n);
            check_eq("start_total", start_cnt, v.exp_n);
            check_eq("busy_after_done", int'(frame_busy_o), 0);
            if (v.tmode == 2) check_eq("result_withheld", int'(withheld > 0), 1);
        end
    endtask

    function automatic int all_outputs();
        return int'(|{frame_busy_o, frame_done_o, load_req_o, load_x_o, load_y_o, load_buf_o,
                      proc_startVar_o, proc_start_o, proc_taken_o, proc_dblBuf_o,
                      proc_numberOfStages_o, proc_inv_window_area_o, out_valid_o,
                      out_passfail_o, out_x_o, out_y_o, out_scale_o});
    endfunction

    vec_t tbl [7];
    vec_t v;

    initial begin
        rst_n = 0; frame_start_i = 0; cfg_x_max_i = '0; cfg_y_max_i = '0; cfg_step_i = '0;
        cfg_scale_i = '0; cfg_stages_i = '0; cfg_inv_area_i = '0;
        clear_model(); n_exp = 0; ack_delay = 0; taken_mode = 0; lat_min = 0; lat_max = 0;
        tbl[0] = '{4, 2, 2, 3, 7, 0, 0, 0, 2, 0, 6};
        tbl[1] = '{0, 0, 1, 1, 2, 0, 0, 0, 1, 0, 1};
        tbl[2] = '{4, 2, 2, 5, 9, 0, 2, 0, 1, 0, 6};
        tbl[3] = '{3, 3, 3, 7, 4, 15, 1, 0, 3, 0, 4};
        tbl[4] = '{2, 5, 4, 2, 3, 1, 1, 0, 3, 0, 2};
        tbl[5] = '{2, 1, 0, 9, 5, 0, 1, 0, 3, 1, 6};
        tbl[6] = '{3, 0, 5, 4, 6, 2, 1, 0, 2, 0, 1};
        repeat (3) @(negedge clk);
        #2;
        check_eq("reset_outputs", all_outputs(), 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start_frame(tbl[i]);
            wait_frame(tbl[i]);
        end

        // Reset while a detection is running and a fill request is pending.
        v = '{4, 2, 2, 6, 3, 15, 0, 25, 25, 0, 6};
        start_frame(v);
        begin
            int c;
            for (c = 0; c < 500 && !(running && load_req_o); c++) begin
                @(negedge clk);
                #2;
            end
            check_eq("reset_setup_reached", int'(c < 500), 1);
        end
        #1;
        rst_n = 0;
        #1;
        check_eq("midreset_load_req", int'(load_req_o), 0);
        check_eq("midreset_busy", int'(frame_busy_o), 0);
        check_eq("midreset_outputs", all_outputs(), 0);
        clear_model();
        proc_valid_i = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        v = '{4, 2, 2, 11, 8, 1, 1, 0, 3, 0, 6};
        start_frame(v);
        wait_frame(v);

        // Randomised frames; expected window count from the raster dimensions.
        for (int r = 0; r < 4; r++) begin
            int s;
            v.xm = $urandom_range(6, 0); v.ym = $urandom_range(4, 0);
            v.st = $urandom_range(3, 0); v.sc = $urandom_range(31, 0);
            v.stg = $urandom_range(31, 0); v.ack = $urandom_range(3, 0);
            v.tmode = 1; v.lmin = 0; v.lmax = 3; v.poke = 0;
            s = (v.st == 0) ? 1 : v.st;
            v.exp_n = (v.xm / s + 1) * (v.ym / s + 1);
            start_frame(v);
            wait_frame(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
